// File: rtl/line_engine_pkg.sv
// Shared graphics definitions for the line rasteriser: FSM encoding,
// coordinate width, frame-buffer base and pixel address packing.
package line_engine_pkg;

  localparam int         COORD_W         = 10;
  localparam logic [9:0] FB_BASE_DEFAULT = 10'h040;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2
  } state_t;

  // Coordinates wrap silently into their 10-bit fields; there is no clipping.
  function automatic logic [31:0] pack_px_addr(input logic [9:0]         base,
                                               input logic [COORD_W-1:0] x,
                                               input logic [COORD_W-1:0] y);
    return {base, y, x, 2'b00};
  endfunction

endpackage

// File: rtl/line_operand_regs.sv
// Shadow registers for the line operands; each strobe captures its value
// every cycle, independent of what the drawing FSM is doing.
module line_operand_regs
  import line_engine_pkg::*;
#(
  parameter int CW = line_engine_pkg::COORD_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [23:0]   i_color,
  input  logic [CW-1:0] i_point,
  input  logic          i_color_valid,
  input  logic          i_x0_valid,
  input  logic          i_y0_valid,
  input  logic          i_x1_valid,
  input  logic          i_y1_valid,
  output logic [23:0]   o_color,
  output logic [CW-1:0] o_x0,
  output logic [CW-1:0] o_y0,
  output logic [CW-1:0] o_x1,
  output logic [CW-1:0] o_y1
);

  logic [23:0]   r_color;
  logic [CW-1:0] r_x0;
  logic [CW-1:0] r_y0;
  logic [CW-1:0] r_x1;
  logic [CW-1:0] r_y1;

  // Several strobes in one cycle all capture the same point value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_color <= '0;
      r_x0    <= '0;
      r_y0    <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
    end else begin
      if (i_color_valid) r_color <= i_color;
      if (i_x0_valid)    r_x0    <= i_point;
      if (i_y0_valid)    r_y0    <= i_point;
      if (i_x1_valid)    r_x1    <= i_point;
      if (i_y1_valid)    r_y1    <= i_point;
    end
  end

  assign o_color = r_color;
  assign o_x0    = r_x0;
  assign o_y0    = r_y0;
  assign o_x1    = r_x1;
  assign o_y1    = r_y1;

endmodule

// File: rtl/line_engine.sv
// Bresenham line rasteriser: latches operands from the processor and emits
// one frame-buffer write per plotted point over a valid/ready port.
//
// state | meaning
// IDLE  | waiting for trigger, line_ready high
// SETUP | one cycle: steep/swap decisions, dx/dy/err initialisation
// DRAW  | presenting pixels, stepping on each accepted write
module line_engine
  import line_engine_pkg::*;
#(
  parameter logic [9:0] FB_BASE = FB_BASE_DEFAULT,
  parameter int         COORD_W = line_engine_pkg::COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        line_color,
  input  logic [COORD_W-1:0] line_point,
  input  logic               line_color_valid,
  input  logic               line_x0_valid,
  input  logic               line_y0_valid,
  input  logic               line_x1_valid,
  input  logic               line_y1_valid,
  input  logic               line_trigger,
  output logic               line_ready,
  output logic [31:0]        px_addr,
  output logic [31:0]        px_data,
  output logic [3:0]         px_we,
  output logic               px_valid,
  input  logic               px_ready
);

  localparam int EW = COORD_W + 2;

  state_t r_state;
  state_t w_state_nxt;

  logic [23:0]        w_sh_color;
  logic [COORD_W-1:0] w_sh_x0, w_sh_y0, w_sh_x1, w_sh_y1;

  logic [23:0]        r_color;
  logic [COORD_W-1:0] r_x0, r_y0, r_x1, r_y1;

  logic               r_steep;
  logic               r_ystep_neg;
  logic [COORD_W-1:0] r_x, r_y, r_xe, r_dx, r_dy;
  logic signed [EW-1:0] r_err;

  logic               w_unused;
  logic               w_accept;
  logic               w_handshake;
  logic               w_last;

  assign w_unused = &{1'b0, line_color[31:24]};

  line_operand_regs #(.CW(COORD_W)) u_operand_regs (
    .clk           (clk),
    .rst           (rst),
    .i_color       (line_color[23:0]),
    .i_point       (line_point),
    .i_color_valid (line_color_valid),
    .i_x0_valid    (line_x0_valid),
    .i_y0_valid    (line_y0_valid),
    .i_x1_valid    (line_x1_valid),
    .i_y1_valid    (line_y1_valid),
    .o_color       (w_sh_color),
    .o_x0          (w_sh_x0),
    .o_y0          (w_sh_y0),
    .o_x1          (w_sh_x1),
    .o_y1          (w_sh_y1)
  );

  // Setup arithmetic on the working copy of the endpoints.
  logic [COORD_W-1:0] w_adx, w_ady;
  logic               w_steep, w_swap;
  logic [COORD_W-1:0] w_ax0, w_ay0, w_ax1, w_ay1;
  logic [COORD_W-1:0] w_sx0, w_sy0, w_sx1, w_sy1;
  logic [COORD_W-1:0] w_dx, w_dy;
  logic               w_yneg;

  assign w_adx   = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
  assign w_ady   = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);
  assign w_steep = w_ady > w_adx;

  assign w_ax0 = w_steep ? r_y0 : r_x0;
  assign w_ay0 = w_steep ? r_x0 : r_y0;
  assign w_ax1 = w_steep ? r_y1 : r_x1;
  assign w_ay1 = w_steep ? r_x1 : r_y1;

  assign w_swap = w_ax0 > w_ax1;
  assign w_sx0  = w_swap ? w_ax1 : w_ax0;
  assign w_sy0  = w_swap ? w_ay1 : w_ay0;
  assign w_sx1  = w_swap ? w_ax0 : w_ax1;
  assign w_sy1  = w_swap ? w_ay0 : w_ay1;

  assign w_dx   = w_sx1 - w_sx0;
  assign w_dy   = (w_sy1 >= w_sy0) ? (w_sy1 - w_sy0) : (w_sy0 - w_sy1);
  assign w_yneg = !(w_sy0 < w_sy1);

  // Error term step for the next x position.
  logic signed [EW-1:0] w_err_dec;
  logic signed [EW-1:0] w_err_fix;

  assign w_err_dec = r_err - $signed({2'b00, r_dy});
  assign w_err_fix = w_err_dec + $signed({2'b00, r_dx});

  assign w_accept    = (r_state == ST_IDLE) && line_trigger;
  assign w_handshake = (r_state == ST_DRAW) && px_ready;
  assign w_last      = (r_x == r_xe);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    line_ready  = 1'b0;
    px_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        line_ready = 1'b1;
        if (line_trigger) w_state_nxt = ST_SETUP;
      end
      ST_SETUP: w_state_nxt = ST_DRAW;
      ST_DRAW: begin
        px_valid = 1'b1;
        if (px_ready && w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_color     <= '0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_x1        <= '0;
      r_y1        <= '0;
      r_steep     <= 1'b0;
      r_ystep_neg <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_xe        <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_err       <= '0;
    end else begin
      if (w_accept) begin
        r_color <= w_sh_color;
        r_x0    <= w_sh_x0;
        r_y0    <= w_sh_y0;
        r_x1    <= w_sh_x1;
        r_y1    <= w_sh_y1;
      end
      if (r_state == ST_SETUP) begin
        r_steep     <= w_steep;
        r_ystep_neg <= w_yneg;
        r_x         <= w_sx0;
        r_y         <= w_sy0;
        r_xe        <= w_sx1;
        r_dx        <= w_dx;
        r_dy        <= w_dy;
        r_err       <= $signed({2'b00, w_dx >> 1});
      end
      if (w_handshake && !w_last) begin
        r_x <= r_x + 1'b1;
        if (w_err_dec < 0) begin
          r_y   <= r_ystep_neg ? (r_y - 1'b1) : (r_y + 1'b1);
          r_err <= w_err_fix;
        end else begin
          r_err <= w_err_dec;
        end
      end
    end
  end

  // Steep lines were drawn with x/y exchanged, so swap them back here.
  assign px_addr = px_valid ? pack_px_addr(FB_BASE, r_steep ? r_y : r_x,
                                           r_steep ? r_x : r_y) : 32'h0;
  assign px_data = px_valid ? {8'h00, r_color} : 32'h0;
  assign px_we   = px_valid ? 4'hF : 4'h0;

endmodule

// File: tb/tb_line_engine.sv
// Directed bench for line_engine: fixed lines with hand-derived pixel
// addresses, backpressure, busy-time writes and mid-line reset.
module tb_line_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] line_color;
  logic [9:0]  line_point;
  logic        line_color_valid, line_x0_valid, line_y0_valid;
  logic        line_x1_valid, line_y1_valid, line_trigger;
  logic        line_ready;
  logic [31:0] px_addr, px_data;
  logic [3:0]  px_we;
  logic        px_valid, px_ready;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  line_engine dut (
    .clk              (clk),
    .rst              (rst),
    .line_color       (line_color),
    .line_point       (line_point),
    .line_color_valid (line_color_valid),
    .line_x0_valid    (line_x0_valid),
    .line_y0_valid    (line_y0_valid),
    .line_x1_valid    (line_x1_valid),
    .line_y1_valid    (line_y1_valid),
    .line_trigger     (line_trigger),
    .line_ready       (line_ready),
    .px_addr          (px_addr),
    .px_data          (px_data),
    .px_we            (px_we),
    .px_valid         (px_valid),
    .px_ready         (px_ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ops(input logic [9:0] x0, input logic [9:0] y0,
                          input logic [9:0] x1, input logic [9:0] y1,
                          input logic [31:0] col);
    line_color = col; line_color_valid = 1'b1;
    line_point = x0;  line_x0_valid = 1'b1;
    step();
    line_color_valid = 1'b0; line_x0_valid = 1'b0;
    line_point = y0;  line_y0_valid = 1'b1;
    step();
    line_y0_valid = 1'b0;
    line_point = x1;  line_x1_valid = 1'b1;
    step();
    line_x1_valid = 1'b0;
    line_point = y1;  line_y1_valid = 1'b1;
    step();
    line_y1_valid = 1'b0;
  endtask

  // Triggers, then walks cycle by cycle; k counts cycles after the trigger cycle.
  task automatic run_line(input string tag, input logic [31:0] col, input bit toggle,
                          input int exp_done, input bit inject);
    int n, first_k, done_k;
    logic [31:0] held;
    bit hold;
    line_trigger = 1'b1;
    step();
    line_trigger = 1'b0;
    n = 0; first_k = -1; done_k = -1; hold = 1'b0; held = '0;
    for (int k = 1; k <= 40; k++) begin
      line_x1_valid = 1'b0;
      line_trigger  = 1'b0;
      if (inject && k == 3) begin
        line_point = 10'd7; line_x1_valid = 1'b1; line_trigger = 1'b1;
      end
      px_ready = toggle ? (k % 2 == 1) : 1'b1;
      if (hold) begin
        chk({tag, " hold"}, px_addr, held);
        hold = 1'b0;
      end
      if (px_valid && first_k < 0) first_k = k;
      if (px_valid && px_ready) begin
        if (n < exp_q.size()) begin
          chk($sformatf("%s addr%0d", tag, n), px_addr, exp_q[n]);
          chk($sformatf("%s data%0d", tag, n), px_data, {8'h00, col[23:0]});
          chk($sformatf("%s we%0d", tag, n), {28'h0, px_we}, 32'hF);
        end
        n++;
      end else if (px_valid) begin
        held = px_addr;
        hold = 1'b1;
      end
      if (line_ready) begin
        done_k = k;
        break;
      end
      step();
    end
    px_ready = 1'b1; line_x1_valid = 1'b0; line_trigger = 1'b0;
    chk({tag, " first_valid"}, first_k, 2);
    chk({tag, " count"}, n, exp_q.size());
    chk({tag, " ready_at"}, done_k, exp_done);
  endtask

  initial begin
    int seen;
    rst = 1'b0; line_color = '0; line_point = '0;
    line_color_valid = 1'b0; line_x0_valid = 1'b0; line_y0_valid = 1'b0;
    line_x1_valid = 1'b0; line_y1_valid = 1'b0; line_trigger = 1'b0;
    px_ready = 1'b1;
    step(); step();
    chk("rst line_ready", {31'h0, line_ready}, 32'h1);
    chk("rst px_valid", {31'h0, px_valid}, 32'h0);
    chk("rst px_we", {28'h0, px_we}, 32'h0);
    chk("rst px_addr", px_addr, 32'h0);
    chk("rst px_data", px_data, 32'h0);
    rst = 1'b1;
    step();

    load_ops(10'd0, 10'd0, 10'd3, 10'd0, 32'h00FF0000);
    exp_q = '{32'h10000000, 32'h10000004, 32'h10000008, 32'h1000000C};
    run_line("horiz", 32'h00FF0000, 1'b0, 6, 1'b0);

    load_ops(10'd0, 10'd0, 10'd1, 10'd3, 32'h12345678);
    exp_q = '{32'h10000000, 32'h10001000, 32'h10002004, 32'h10003004};
    run_line("steep", 32'h12345678, 1'b0, 6, 1'b0);

    load_ops(10'd3, 10'd0, 10'd0, 10'd0, 32'h00000ABC);
    exp_q = '{32'h10000000, 32'h10000004, 32'h10000008, 32'h1000000C};
    run_line("reversed", 32'h00000ABC, 1'b0, 6, 1'b0);

    load_ops(10'd0, 10'd2, 10'd4, 10'd0, 32'h00112233);
    exp_q = '{32'h10002000, 32'h10002004, 32'h10001008, 32'h1000100C, 32'h10000010};
    run_line("descend", 32'h00112233, 1'b0, 7, 1'b0);

    load_ops(10'd5, 10'd7, 10'd5, 10'd7, 32'h00C0FFEE);
    exp_q = '{32'h10007014};
    run_line("single", 32'h00C0FFEE, 1'b0, 3, 1'b0);

    load_ops(10'd0, 10'd0, 10'd3, 10'd0, 32'h00FF0000);
    exp_q = '{32'h10000000, 32'h10000004, 32'h10000008, 32'h1000000C};
    run_line("backpr", 32'h00FF0000, 1'b1, 10, 1'b0);

    load_ops(10'd0, 10'd0, 10'd3, 10'd0, 32'h00FF0000);
    run_line("busy", 32'h00FF0000, 1'b0, 6, 1'b1);
    step(); step();
    chk("busy dropped trig ready", {31'h0, line_ready}, 32'h1);
    chk("busy dropped trig valid", {31'h0, px_valid}, 32'h0);
    exp_q = '{32'h10000000, 32'h10000004, 32'h10000008, 32'h1000000C,
              32'h10000010, 32'h10000014, 32'h10000018, 32'h1000001C};
    run_line("new_x1", 32'h00FF0000, 1'b0, 10, 1'b0);

    load_ops(10'd0, 10'd0, 10'd9, 10'd0, 32'h00ABCDEF);
    line_trigger = 1'b1;
    step();
    line_trigger = 1'b0;
    step(); step();
    chk("midrst drawing", {31'h0, px_valid}, 32'h1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst px_valid", {31'h0, px_valid}, 32'h0);
    chk("midrst line_ready", {31'h0, line_ready}, 32'h1);
    chk("midrst px_addr", px_addr, 32'h0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (px_valid) seen++;
    end
    chk("midrst no writes", seen, 0);
    exp_q = '{32'h10000000};
    run_line("postrst", 32'h00000000, 1'b0, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
